// File: rtl/trig_pkg.sv
// Shared constants and state encoding for the pulse-repetition sequencer.
package trig_pkg;

    localparam int NCH       = 4;
    localparam int CHW       = $clog2(NCH);
    localparam int MIN_PER   = 64;
    localparam int SETUP_CYC = 4;
    localparam int TRIG_HI   = 8;
    localparam int PH_W      = 4;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_SETUP = 5'b00010,
        S_FIRE  = 5'b00100,
        S_WAIT  = 5'b01000,
        S_STOP  = 5'b10000
    } state_t;

endpackage

// File: rtl/rr_next_ch.sv
// Combinational round-robin finder: first enabled channel at (incl) or after cur,
// wrapping modulo NCH; wrap flags that the result did not move forward.
module rr_next_ch
    import trig_pkg::*;
(
    input  logic [NCH-1:0] mask,
    input  logic [CHW-1:0] cur,
    input  logic           incl,
    output logic [CHW-1:0] nxt,
    output logic           found,
    output logic           wrap
);

    int idx;

    always_comb begin
        nxt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(cur) + k + (incl ? 0 : 1)) % NCH;
            if (!found && mask[idx]) begin
                found = 1'b1;
                nxt   = CHW'(idx);
            end
        end
        wrap = found && (nxt <= cur);
    end

endmodule

// File: rtl/trig_sequencer.sv
// Pulse-repetition scheduler: one shot per period, round-robin over enabled channels,
// presenting per-channel delay/pulse to trigwave and flagging acquisition overruns.
//
//   state | meaning
//   IDLE  | not scanning; waits for start
//   SETUP | mux select driven, settling before the trigger edge
//   FIRE  | o_trig high for TRIG_HI cycles
//   WAIT  | remainder of the repetition period
//   STOP  | remainder of the period after a stop request, then IDLE
module trig_sequencer
    import trig_pkg::*;
#(
    parameter int PER_W = 24
) (
    input  logic             i_clk100M,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [PER_W-1:0] i_period,
    input  logic [NCH-1:0]   i_ch_mask,
    input  logic             i_cfg_we,
    input  logic [CHW-1:0]   i_cfg_ch,
    input  logic [7:0]       i_cfg_delay,
    input  logic [11:0]      i_cfg_pulse,
    input  logic             i_acq_done,
    output logic             o_trig,
    output logic [7:0]       o_delay,
    output logic [11:0]      o_pulse,
    output logic [CHW-1:0]   o_ch_sel,
    output logic             o_acq_start,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_overrun
);

    state_t           state, state_n;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] eff_per;
    logic [PH_W-1:0]  ph_cnt;
    logic [19:0]      cfg [NCH];
    logic             stop_pend;
    logic             acq_seen;
    logic             rr_incl, rr_found, rr_wrap;
    logic [CHW-1:0]   rr_nxt;
    logic             sel_load, clr_ovr;
    logic             per_zero, ph_zero, stop_req, draining, fd_n;

    assign eff_per  = (i_period < PER_W'(MIN_PER)) ? PER_W'(MIN_PER) : i_period;
    assign per_zero = (per_cnt == '0);
    assign ph_zero  = (ph_cnt == '0);
    assign stop_req = stop_pend | i_stop;
    assign draining = (state == S_WAIT) || (state == S_STOP);

    rr_next_ch u_rr (
        .mask  (i_ch_mask),
        .cur   (o_ch_sel),
        .incl  (rr_incl),
        .nxt   (rr_nxt),
        .found (rr_found),
        .wrap  (rr_wrap)
    );

    always_ff @(posedge i_clk100M or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        rr_incl  = 1'b0;
        sel_load = 1'b0;
        clr_ovr  = 1'b0;
        case (state)
            S_IDLE: begin
                // Resume at the pointer itself, not after it
                rr_incl = 1'b1;
                if (i_start && !i_stop && rr_found) begin
                    state_n  = S_SETUP;
                    sel_load = 1'b1;
                    clr_ovr  = 1'b1;
                end
            end
            S_SETUP: begin
                if (ph_zero) state_n = S_FIRE;
            end
            S_FIRE: begin
                if (ph_zero) state_n = stop_req ? S_STOP : S_WAIT;
            end
            S_WAIT: begin
                if (per_zero) begin
                    if (stop_req || !rr_found) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n  = S_SETUP;
                        sel_load = 1'b1;
                    end
                end else if (i_stop) begin
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (per_zero) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk100M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            per_cnt <= '0;
            ph_cnt  <= '0;
        end else begin
            // Period count runs from SETUP entry so shot spacing is exactly eff_per
            if (sel_load)          per_cnt <= eff_per - PER_W'(1);
            else if (!per_zero)    per_cnt <= per_cnt - PER_W'(1);

            if (sel_load)                        ph_cnt <= PH_W'(SETUP_CYC - 1);
            else if (state == S_SETUP && ph_zero) ph_cnt <= PH_W'(TRIG_HI - 1);
            else if (!ph_zero)                   ph_cnt <= ph_cnt - PH_W'(1);
        end
    end

    always_ff @(posedge i_clk100M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NCH; i++) cfg[i] <= '0;
        end else if (i_cfg_we && (int'(i_cfg_ch) < NCH)) begin
            cfg[i_cfg_ch] <= {i_cfg_delay, i_cfg_pulse};
        end
    end

    always_ff @(posedge i_clk100M or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ch_sel <= '0;
            o_delay  <= '0;
            o_pulse  <= '0;
        end else if (sel_load) begin
            o_ch_sel <= rr_nxt;
            o_delay  <= cfg[rr_nxt][19:12];
            o_pulse  <= cfg[rr_nxt][11:0];
        end
    end

    always_ff @(posedge i_clk100M or negedge i_rst_n) begin
        if (!i_rst_n)              stop_pend <= 1'b0;
        else if (state == S_IDLE)  stop_pend <= 1'b0;
        else if (i_stop)           stop_pend <= 1'b1;
    end

    // Acquisition completion counts from the trigger onward, for the current shot only
    always_ff @(posedge i_clk100M or negedge i_rst_n) begin
        if (!i_rst_n)                                  acq_seen <= 1'b0;
        else if (sel_load)                             acq_seen <= 1'b0;
        else if (i_acq_done && (state == S_FIRE || draining)) acq_seen <= 1'b1;
    end

    always_ff @(posedge i_clk100M or negedge i_rst_n) begin
        if (!i_rst_n)                                          o_overrun <= 1'b0;
        else if (clr_ovr)                                      o_overrun <= 1'b0;
        else if (draining && per_zero && !(acq_seen || i_acq_done)) o_overrun <= 1'b1;
    end

    assign fd_n = draining && per_zero && rr_found && rr_wrap;

    always_ff @(posedge i_clk100M or negedge i_rst_n) begin
        if (!i_rst_n) o_frame_done <= 1'b0;
        else          o_frame_done <= fd_n;
    end

    assign o_trig      = (state == S_FIRE);
    assign o_acq_start = o_trig && (ph_cnt == PH_W'(TRIG_HI - 1));
    assign o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer: shot spacing, channel order, config latching,
// overrun, stop handling and async reset.
module tb_trig_sequencer;
    import trig_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, cfg_we, acq_done;
    logic [23:0]      period;
    logic [NCH-1:0]   mask;
    logic [CHW-1:0]   cfg_ch;
    logic [7:0]       cfg_delay;
    logic [11:0]      cfg_pulse;
    logic             trig, acq_start, busy, frame_done, overrun;
    logic [7:0]       delay;
    logic [11:0]      pulse;
    logic [CHW-1:0]   ch_sel;

    int errors = 0;
    int checks = 0;

    trig_sequencer #(.PER_W(24)) dut (
        .i_clk100M    (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_stop       (stop),
        .i_period     (period),
        .i_ch_mask    (mask),
        .i_cfg_we     (cfg_we),
        .i_cfg_ch     (cfg_ch),
        .i_cfg_delay  (cfg_delay),
        .i_cfg_pulse  (cfg_pulse),
        .i_acq_done   (acq_done),
        .o_trig       (trig),
        .o_delay      (delay),
        .o_pulse      (pulse),
        .o_ch_sel     (ch_sel),
        .o_acq_start  (acq_start),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Monitor samples 1 ns after each rising edge
    int   cyc = 0;
    logic prev_trig = 1'b0;
    int   hi_cnt = 0;
    int   last_width = 0;
    int   bad_acq = 0;
    int   rise_cyc[$];
    int   rise_ch[$];
    int   rise_dly[$];
    int   fd_cyc[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (trig && !prev_trig) begin
            rise_cyc.push_back(cyc);
            rise_ch.push_back(int'(ch_sel));
            rise_dly.push_back(int'(delay));
        end
        if (trig) hi_cnt++;
        else if (prev_trig) begin
            last_width = hi_cnt;
            hi_cnt = 0;
        end
        if (frame_done) fd_cyc.push_back(cyc);
        if (acq_start !== (trig && !prev_trig)) bad_acq++;
        prev_trig = trig;
    end

    function automatic int rc(input int i);
        return (i < rise_cyc.size()) ? rise_cyc[i] : -1;
    endfunction
    function automatic int rch(input int i);
        return (i < rise_ch.size()) ? rise_ch[i] : -1;
    endfunction
    function automatic int rdl(input int i);
        return (i < rise_dly.size()) ? rise_dly[i] : -1;
    endfunction
    function automatic int fd_between(input int a, input int b);
        int n = 0;
        foreach (fd_cyc[i]) if (fd_cyc[i] > a && fd_cyc[i] <= b) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rises(input int target, input int budget, input string tag);
        int k = 0;
        while (rise_cyc.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, int'(rise_cyc.size() >= target), 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, int'(busy), 0);
    endtask

    task automatic cfg_write(input int ch, input int d, input int p);
        cfg_we    = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_delay = 8'(d);
        cfg_pulse = 12'(p);
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int b;
    int exp_ch[6]  = '{0, 1, 3, 0, 1, 3};
    int exp_dly[6] = '{10, 21, 33, 10, 21, 33};

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0; acq_done = 1'b0;
        period = 24'd0; mask = '0; cfg_ch = '0; cfg_delay = '0; cfg_pulse = '0;
        repeat (3) @(negedge clk);
        chk("rst_trig", int'(trig), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({delay, pulse, ch_sel, acq_start, frame_done, overrun}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single channel, period 1000
        cfg_write(0, 10, 50);
        mask = 4'b0001; period = 24'd1000;
        @(negedge clk);
        pulse_start();
        chk("t1_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        chk("t1_trig_pre", int'(trig), 0);
        @(negedge clk);
        chk("t1_trig_edge", int'(trig), 1);
        chk("t1_acq_start", int'(acq_start), 1);
        b = rise_cyc.size() - 1;
        wait_rises(b + 3, 2200, "t1_rises");
        chk("t1_space0", rc(b + 1) - rc(b), 1000);
        chk("t1_space1", rc(b + 2) - rc(b + 1), 1000);
        chk("t1_delay", rdl(b + 2), 10);
        chk("t1_pulse", int'(pulse), 50);
        chk("t1_ch", rch(b + 1), 0);
        chk("t1_frame_done", fd_between(rc(b), rc(b + 2)), 2);
        @(negedge clk);
        pulse_stop();
        wait_idle(1100, "t1_idle");
        chk("t1_width", last_width, TRIG_HI);

        // 2: mask 1011, acquisition keeps up
        cfg_write(1, 21, 100);
        cfg_write(3, 33, 300);
        mask = 4'b1011; period = 24'd100; acq_done = 1'b1;
        b = rise_cyc.size();
        pulse_start();
        wait_rises(b + 6, 800, "t2_rises");
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_ch%0d", i), rch(b + i), exp_ch[i]);
            chk($sformatf("t2_dly%0d", i), rdl(b + i), exp_dly[i]);
        end
        chk("t2_space", rc(b + 4) - rc(b + 3), 100);
        chk("t2_fd_mid", fd_between(rc(b), rc(b + 2)), 0);
        chk("t2_fd_wrap", fd_between(rc(b + 2), rc(b + 3)), 1);
        chk("t2_overrun", int'(overrun), 0);
        pulse_stop();
        wait_idle(300, "t2_idle");

        // 3: short period clamps to 64; acquisition never completes
        mask = 4'b0001; period = 24'd10; acq_done = 1'b0;
        b = rise_cyc.size();
        pulse_start();
        chk("t3_ovr_clr", int'(overrun), 0);
        wait_rises(b + 3, 300, "t3_rises");
        chk("t3_space0", rc(b + 1) - rc(b), 64);
        chk("t3_space1", rc(b + 2) - rc(b + 1), 64);
        chk("t3_ch", rch(b), 0);
        chk("t3_overrun", int'(overrun), 1);
        chk("t3_busy", int'(busy), 1);
        pulse_stop();
        wait_idle(200, "t3_idle");
        chk("t3_sticky", int'(overrun), 1);
        pulse_start();
        chk("t3_restart_clr", int'(overrun), 0);
        pulse_stop();
        wait_idle(200, "t3_idle2");

        // 4: rewrite active channel config mid-FIRE
        cfg_write(1, 5, 70);
        mask = 4'b0011; period = 24'd100; acq_done = 1'b1;
        b = rise_cyc.size();
        pulse_start();
        wait_rises(b + 2, 300, "t4_rises");
        chk("t4_ch_first", rch(b), 0);
        chk("t4_ch_second", rch(b + 1), 1);
        chk("t4_dly_old", rdl(b + 1), 5);
        cfg_write(1, 99, 7);
        chk("t4_dly_held", int'(delay), 5);
        chk("t4_pul_held", int'(pulse), 70);
        wait_rises(b + 4, 300, "t4_rises2");
        chk("t4_ch_next", rch(b + 3), 1);
        chk("t4_dly_new", rdl(b + 3), 99);
        chk("t4_pul_new", int'(pulse), 7);
        pulse_stop();
        wait_idle(300, "t4_idle");

        // 5: stop during SETUP; start+stop together in IDLE
        mask = 4'b0001; period = 24'd100;
        b = rise_cyc.size();
        pulse_start();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (98) @(negedge clk);
        chk("t5_busy_end", int'(busy), 1);
        @(negedge clk);
        chk("t5_idle", int'(busy), 0);
        chk("t5_one_shot", rise_cyc.size() - b, 1);
        chk("t5_width", last_width, TRIG_HI);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        repeat (20) @(negedge clk);
        chk("t5_startstop_busy", int'(busy), 0);
        chk("t5_startstop_trig", rise_cyc.size() - b, 1);

        // 6: async reset during the first FIRE cycle
        pulse_start();
        repeat (4) @(negedge clk);
        chk("t6_trig_before", int'(trig), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_trig_rst", int'(trig), 0);
        chk("t6_busy_rst", int'(busy), 0);
        chk("t6_acq_rst", int'(acq_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        b = rise_cyc.size();
        repeat (300) @(negedge clk);
        chk("t6_no_trig", rise_cyc.size() - b, 0);
        chk("t6_cfg_rst", int'({delay, pulse, ch_sel}), 0);
        chk("acq_start_align", bad_acq, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
